// File: rtl/m31_pkg.sv
// Mersenne-31 field helpers shared by the circulant MDS multiplier.
// All helpers expect and return canonical elements unless noted.
package m31_pkg;

  localparam int N = 16;
  localparam int W = 31;
  localparam logic [W-1:0] P = 31'h7FFFFFFF;

  typedef logic [W-1:0] felem_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // a + b with both operands canonical, so a single conditional subtract suffices.
  function automatic felem_t m31_add(input felem_t a, input felem_t b);
    logic [W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, P}) s = s - {1'b0, P};
    return s[W-1:0];
  endfunction

  // Two folds bring any 62-bit product below 2^31; one compare canonicalises p itself.
  function automatic felem_t m31_reduce62(input logic [2*W-1:0] x);
    logic [W:0] s;
    logic [W:0] t;
    s = {1'b0, x[2*W-1:W]} + {1'b0, x[W-1:0]};
    t = {1'b0, s[W-1:0]} + {{W{1'b0}}, s[W]};
    if (t >= {1'b0, P}) t = t - {1'b0, P};
    return t[W-1:0];
  endfunction

endpackage

// File: rtl/m31_mul.sv
// Combinational 31x31 modular multiplier over p = 2^31 - 1.
// Accepts any 31-bit operand, including the non-canonical encoding of zero.
module m31_mul
  import m31_pkg::*;
(
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_p
);

  logic [2*W-1:0] w_prod;

  assign w_prod = {{W{1'b0}}, i_a} * {{W{1'b0}}, i_b};
  assign o_p    = m31_reduce62(w_prod);

endmodule

// File: rtl/circ_mtx_vec_mul_m31.sv
// 16x16 circulant matrix x vector over Mersenne-31: one input column per cycle,
// 16 lanes each accumulating mtx_row[(k - i) mod 16] * vec[k].
module circ_mtx_vec_mul_m31
  import m31_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_start,
  input  logic [N-1:0][W-1:0] i_mtx_row,
  input  logic [N-1:0][W-1:0] i_vec,
  output logic                o_busy,
  output logic                o_done,
  output logic [N-1:0][W-1:0] o_result
);

  state_t              r_state;
  logic [3:0]          r_k;
  logic                r_busy;
  logic                r_done;
  logic [N-1:0][W-1:0] r_mtx;
  logic [N-1:0][W-1:0] r_vec;
  logic [N-1:0][W-1:0] r_acc;
  logic [N-1:0][W-1:0] r_result;

  logic [W-1:0]        w_vk;
  logic [N-1:0][W-1:0] w_coef;
  logic [N-1:0][W-1:0] w_prod;
  logic [N-1:0][W-1:0] w_acc_nxt;

  assign w_vk = r_vec[r_k];

  // Lane i sees the first row rotated right by i; the 4-bit subtract is the mod-16 wrap.
  for (genvar gi = 0; gi < N; gi++) begin : g_lane
    localparam logic [3:0] LANE = 4'(gi);
    logic [3:0] w_idx;

    assign w_idx         = r_k - LANE;
    assign w_coef[gi]    = r_mtx[w_idx];
    assign w_acc_nxt[gi] = m31_add(r_acc[gi], w_prod[gi]);

    m31_mul u_mul (
      .i_a (w_coef[gi]),
      .i_b (w_vk),
      .o_p (w_prod[gi])
    );
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= IDLE;
      r_k      <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_mtx    <= '0;
      r_vec    <= '0;
      r_acc    <= '0;
      r_result <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (i_start) begin
            r_mtx   <= i_mtx_row;
            r_vec   <= i_vec;
            r_acc   <= '0;
            r_k     <= '0;
            r_busy  <= 1'b1;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_acc <= w_acc_nxt;
          r_k   <= r_k + 4'd1;
          // Last column: publish the sums directly so result never shows a partial value.
          if (r_k == 4'd15) begin
            r_result <= w_acc_nxt;
            r_done   <= 1'b1;
            r_busy   <= 1'b0;
            r_state  <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_busy   = r_busy;
  assign o_done   = r_done;
  assign o_result = r_result;

endmodule

// File: tb/tb_circ_mtx_vec_mul_m31.sv
// Directed bench for the Mersenne-31 circulant multiplier: identity, rotation,
// reduction corners, MDS golden vectors, control corners and mid-run reset.
module tb_circ_mtx_vec_mul_m31;

  localparam logic [30:0] PM = 31'h7FFFFFFF;
  localparam logic [30:0] PM1 = 31'h7FFFFFFE;

  logic                 clk;
  logic                 rst_n;
  logic                 start;
  logic [15:0][30:0]    mtx_row;
  logic [15:0][30:0]    vec;
  logic                 busy;
  logic                 done;
  logic [15:0][30:0]    result;

  int n_vec;
  int n_err;

  circ_mtx_vec_mul_m31 dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_start   (start),
    .i_mtx_row (mtx_row),
    .i_vec     (vec),
    .o_busy    (busy),
    .o_done    (done),
    .o_result  (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Straight sum-of-products reference using 64-bit % arithmetic.
  function automatic logic [15:0][30:0] model(input logic [15:0][30:0] m,
                                              input logic [15:0][30:0] v);
    logic [15:0][30:0] r;
    longint unsigned acc, a, b, p;
    p = 64'h7FFFFFFF;
    for (int i = 0; i < 16; i++) begin
      acc = 0;
      for (int j = 0; j < 16; j++) begin
        a = {33'd0, m[(j - i + 16) % 16]} % p;
        b = {33'd0, v[j]} % p;
        acc = (acc + (a * b) % p) % p;
      end
      r[i] = acc[30:0];
    end
    return r;
  endfunction

  task automatic chk_res(input string name, input logic [15:0][30:0] exp);
    n_vec++;
    if (result !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, result, exp);
    end
  endtask

  task automatic chk_int(input string name, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", name, got, exp);
    end
  endtask

  // Called at a negedge; start is seen by the following posedge.
  task automatic launch(input logic [15:0][30:0] m, input logic [15:0][30:0] v);
    mtx_row = m;
    vec     = v;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
  endtask

  // Returns at the negedge where done is high (or after a bounded timeout).
  task automatic wait_done(output int cyc, output int bcnt);
    cyc  = 0;
    bcnt = busy ? 1 : 0;
    while (done !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (busy === 1'b1) bcnt++;
    end
  endtask

  task automatic run(input string name, input logic [15:0][30:0] m,
                     input logic [15:0][30:0] v, input logic [15:0][30:0] exp);
    int cyc, bcnt;
    launch(m, v);
    wait_done(cyc, bcnt);
    chk_int({name, "_lat"}, cyc, 16);
    chk_res(name, exp);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    start = 1'b0;
    mtx_row = '0;
    vec = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_vec++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_vec++;
    if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
    chk_res("reset_result", '0);
  endtask

  task automatic test_identity;
    logic [15:0][30:0] m, v;
    int cyc, bcnt;
    m = '0;
    m[0] = 31'd1;
    for (int i = 0; i < 16; i++) v[i] = 31'(i);
    launch(m, v);
    wait_done(cyc, bcnt);
    chk_int("ident_lat", cyc, 16);
    chk_int("ident_busy_cycles", bcnt, 16);
    chk_res("ident", v);
    @(negedge clk);
    n_vec++;
    if (done !== 1'b0) begin n_err++; $display("FAIL ident_done_pulse: got %b want 0", done); end
  endtask

  task automatic test_rotation;
    logic [15:0][30:0] m, v, e;
    m = '0; m[1] = 31'd1;
    v = '0; v[5] = 31'd7;
    e = '0; e[4] = 31'd7;
    run("rot_mid", m, v, e);
    v = '0; v[0] = 31'd7;
    e = '0; e[15] = 31'd7;
    run("rot_wrap", m, v, e);
  endtask

  task automatic test_reduction;
    logic [15:0][30:0] m, v, e;
    m = '0; m[0] = PM1;
    v = {16{PM1}};
    e = {16{31'd1}};
    run("red_pm1_sq", m, v, e);
    run("red_ones", {16{31'd1}}, {16{31'd1}}, {16{31'd16}});
    run("red_all_pm1", {16{PM1}}, {16{PM1}}, {16{31'd16}});
    run("red_vec_p_is_zero", {16{31'd1}}, {16{PM}}, '0);
    run("red_mtx_p_is_zero", {16{PM}}, {16{31'd12345}}, '0);
  endtask

  task automatic test_golden;
    int mds[16] = '{61402, 17845, 26798, 59689, 12021, 40901, 41351, 27521,
                    56951, 12034, 53865, 43244, 7454, 33823, 28750, 1108};
    logic [15:0][30:0] m, v, e;
    int cyc, bcnt;
    for (int i = 0; i < 16; i++) m[i] = 31'(mds[i]);
    // Unit vector e0 reads column 0: result[i] = m[(0 - i) mod 16].
    v = '0; v[0] = 31'd1;
    for (int i = 0; i < 16; i++) e[i] = m[(16 - i) % 16];
    run("mds_e0", m, v, e);
    // Random canonical vectors, each new start issued in the previous done cycle.
    for (int i = 0; i < 16; i++) v[i] = 31'($urandom_range(32'h7FFFFFFE, 0));
    launch(m, v);
    for (int r = 0; r < 16; r++) begin
      wait_done(cyc, bcnt);
      chk_int($sformatf("mds_b2b%0d_lat", r), cyc, 16);
      chk_res($sformatf("mds_b2b%0d", r), model(m, v));
      if (r != 15) begin
        for (int i = 0; i < 16; i++) v[i] = 31'($urandom_range(32'h7FFFFFFE, 0));
        launch(m, v);
      end
    end
  endtask

  task automatic test_start_ignored;
    logic [15:0][30:0] m, v, e;
    int cyc;
    for (int i = 0; i < 16; i++) begin
      m[i] = 31'(3 * i + 1);
      v[i] = 31'(1000 + 17 * i);
    end
    e = model(m, v);
    launch(m, v);
    cyc = 0;
    while (done !== 1'b1 && cyc < 40) begin
      mtx_row = {16{31'h55555555}};
      vec     = {16{31'h2AAAAAAA}};
      start   = (cyc == 3 || cyc == 10);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk_int("ign_lat", cyc, 16);
    chk_res("ign_result", e);
    @(negedge clk);
    n_vec++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL ign_no_restart: got %b want 0", busy); end
  endtask

  task automatic test_reset_mid;
    logic [15:0][30:0] m, v;
    m = '0; m[0] = 31'd1;
    for (int i = 0; i < 16; i++) v[i] = 31'(i + 100);
    launch({16{31'd9}}, {16{31'd9}});
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    n_vec++;
    if (done !== 1'b0) begin n_err++; $display("FAIL rstmid_done: got %b want 0", done); end
    chk_res("rstmid_result", '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run("rstmid_after", m, v, v);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_identity();
    test_rotation();
    test_reduction();
    test_golden();
    test_start_ignored();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/circ_mtx_vec_mul_m31.md
# circ_mtx_vec_mul_m31

Clocked 16×16 circulant matrix × vector multiplier over the Mersenne-31 field (p = 2^31 − 1). It serves as the MDS linear layer of the Monolith permutation datapath. The circulant matrix is supplied as its first row. The block accumulates one input column per cycle with 16 parallel modular multipliers and returns 16 canonical field elements.

## Interface
- N, 16: vector length and matrix dimension; only 16 is supported.
- W, 31: element width, fixed by the field.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; sampled on a rising edge.
- mtx_row  in  N×W  first row of the circulant matrix, elements 0..15.
- vec  in  N×W  input vector, elements 0..15.
- busy  out  1  computation in progress.
- done  out  1  one-cycle pulse; result just updated.
- result  out  N×W  output vector; canonical, each element < p.

## Operation
- Circulant rule: result[i] = Σ_j mtx_row[(j − i) mod 16] · vec[j] mod p.
  - Row i of the matrix is the first row rotated right by i.
- Input encoding:
  - Any 31-bit input is accepted.
  - 0x7FFFFFFF is congruent to 0.
- Start acceptance:
  - start is accepted only when busy=0.
  - On acceptance, mtx_row and vec are latched into internal registers and all 16 accumulators are cleared.
  - Inputs may change freely afterwards.
- Iteration k = 0..15:
  - For every i, acc[i] ← (acc[i] + mtx_row_q[(k − i) mod 16] · vec_q[k]) mod p.
  - k is a 4-bit counter.
  - The index (k − i) mod 16 is a 4-bit wrap-around subtraction.
- Modular multiply:
  - Form the 62-bit product x.
  - Fold: s = x[61:31] + x[30:0].
  - Fold again: t = s[31] + s[30:0].
  - If t ≥ p, subtract p.
- Modular add: a + b (32-bit); if the sum ≥ p, subtract p.
- Completion: after iteration 15, the accumulators are copied to result.
  - result holds until the next completion or reset.
  - It is never updated mid-computation.
- start while busy=1 is ignored and does not disturb the computation.

## Timing
- Reset values: busy=0, done=0, result all 0, counter=0, accumulators 0.
- Start and busy:
  - start accepted at edge t → busy=1 from edge t.
  - Iterations occur on edges t+1 .. t+16.
- Completion at edge t+16:
  - result is valid.
  - done=1 for exactly one cycle.
  - busy=0.
- Latency: 16 cycles from the accepting edge to done; throughput is one vector per 16 cycles.
- A new start may be accepted at the edge ending the done cycle (edge t+17), i.e. back-to-back.
- Reset asserted mid-operation:
  - Computation is aborted immediately.
  - All outputs return to reset values; the previous result is cleared.
- The path from start to busy is registered; there are no combinational input-to-output paths.

## Structure
- Package m31_pkg:
  - P = 31'h7FFFFFFF
  - W = 31
  - N = 16
  - typedef felem_t = logic [30:0]
  - functions m31_add and m31_reduce62
- Sub-module m31_mul:
  - combinational 31×31 modular multiplier built on m31_reduce62;
  - instantiated N times in a generate loop.
- Top level contains:
  - latch registers;
  - the 4-bit counter;
  - a busy/done control of two states, IDLE and RUN;
  - accumulators and the result register.
- State transitions:
  - IDLE → RUN on start.
  - RUN → IDLE when the counter reaches 15.

## Test plan
- Identity: mtx_row = [1, 0, …, 0], vec = [0..15] → result = [0..15]; done 16 cycles after start; busy high for exactly 16 cycles.
- Rotation check: mtx_row = [0, 1, 0, …, 0], vec[5] = 7, others 0 → result[4] = 7, all others 0. Repeat with vec[0] = 7 → result[15] = 7 (wrap-around).
- Reduction:
  - mtx_row = [p−1, 0, …], vec all p−1 → every result = 1.
  - mtx_row all ones, vec all ones → every result = 16.
  - mtx_row all p−1, vec all p−1 → every result = 16.
  - vec = 0x7FFFFFFF treated as 0 → result all 0.
- Golden vectors: the Monolith-31 MDS first row with 16 random canonical vectors → result matches the software model element-wise. Include back-to-back starts issued in the done cycle.
- Control edges:
  - start pulsed at cycles 3 and 10 of a run → ignored; result equals a single-run value.
  - Changing inputs after acceptance has no effect.
- Reset: rst_n low at cycle 8 of a run → busy=0, done=0, result all 0 immediately. A subsequent start completes normally.
